regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file for the shrv32 core, successor to the single-clock-pair two-port file. It provides NRD synchronous read ports and one write port on a single clock, keeps x0 hardwired to zero, and adds a per-register pending scoreboard and a sequenced bulk-clear engine. It sits between decode (read addresses) and writeback (write port), with a debug tap replacing the fixed LED output.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_mp_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_mp.sv | 128 ++++++++++++
 tb/tb_regfile_mp.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults, clear-engine state encoding and address-width helper for regfile_mp.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  function automatic int aw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback/debug-facing bundle of regfile_mp; master drives requests, slave is the file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF
);
  localparam int AW = aw_of(NREG);

  logic                 RE;
  logic [NRD*AW-1:0]    RA;
  logic [NRD*XLEN-1:0]  RD;
  logic [NRD-1:0]       RPEND;
  logic                 WE;
  logic [AW-1:0]        WA;
  logic [XLEN-1:0]      WD;
  logic                 RSV_EN;
  logic [AW-1:0]        RSV_A;
  logic                 CLR_REQ;
  logic                 CLR_BUSY;
  logic [AW-1:0]        DBG_SEL;
  logic [XLEN-1:0]      DBG;

  modport master (
    output RE, RA, WE, WA, WD, RSV_EN, RSV_A, CLR_REQ, DBG_SEL,
    input  RD, RPEND, CLR_BUSY, DBG
  );

  modport slave (
    input  RE, RA, WE, WA, WD, RSV_EN, RSV_A, CLR_REQ, DBG_SEL,
    output RD, RPEND, CLR_BUSY, DBG
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: flush clears all, release clears one, reserve sets one (reserve wins).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  parameter int AW   = aw_of(NREG)
) (
  input  logic              CLK_DC,
  input  logic              RST,
  input  logic              flush,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_a,
  input  logic              rel_en,
  input  logic [AW-1:0]     rel_a,
  input  logic [NRD*AW-1:0] lk_a,
  output logic [NRD-1:0]    lk_pend
);

  logic [NREG-1:0] pend_q;

  // Later non-blocking assignment takes effect, so a same-address reserve overrides the release.
  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      pend_q <= '0;
    end else if (flush) begin
      pend_q <= '0;
    end else begin
      if (rel_en) pend_q[rel_a] <= 1'b0;
      if (rsv_en) pend_q[rsv_a] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_lk
    assign lk_pend[g] = pend_q[lk_a[g*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending scoreboard, bulk-clear engine and debug tap.
// Optional write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
//
// state    | meaning
// CLR_IDLE | normal operation; writes, reserves and clear requests accepted
// CLR_RUN  | zeroing one register per cycle from x1 up to x(NREG-1)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF
) (
  input logic         CLK_DC,
  input logic         RST,
  regfile_mp_if.slave bus
);

  localparam int AW = aw_of(NREG);

  clr_state_t      state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] regs   [NREG];
  logic [XLEN-1:0] rd_q   [NRD];
  logic [XLEN-1:0] rd_nxt [NRD];
  logic [AW-1:0]   ra     [NRD];
  logic [NRD-1:0]  rpend_q, rp_nxt, lk_pend;
  logic [XLEN-1:0] dbg_q;
  logic            idle, wr_ok, rsv_ok, flush;

  assign idle   = (state_q == CLR_IDLE);
  assign wr_ok  = idle && bus.WE && (bus.WA != '0);
  assign rsv_ok = idle && bus.RSV_EN && (bus.RSV_A != '0);
  assign flush  = idle && bus.CLR_REQ;

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      state_q <= CLR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (bus.CLR_REQ) begin
          state_d = CLR_RUN;
          idx_d   = AW'(1);
        end
      end
      CLR_RUN: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NREG - 1)) state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // x0 is never written, so its reset value keeps it hardwired to zero.
  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else if (wr_ok) begin
      regs[bus.WA] <= bus.WD;
    end else if (state_q == CLR_RUN) begin
      regs[idx_q] <= '0;
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) u_sb (
    .CLK_DC  (CLK_DC),
    .RST     (RST),
    .flush   (flush),
    .rsv_en  (rsv_ok),
    .rsv_a   (bus.RSV_A),
    .rel_en  (wr_ok),
    .rel_a   (bus.WA),
    .lk_a    (bus.RA),
    .lk_pend (lk_pend)
  );

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      ra[i]     = bus.RA[i*AW +: AW];
      rd_nxt[i] = (ra[i] == '0) ? '0 : regs[ra[i]];
      rp_nxt[i] = lk_pend[i];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.WA == ra[i])) begin
        rd_nxt[i] = bus.WD;
        rp_nxt[i] = rsv_ok && (bus.RSV_A == ra[i]);
      end
`endif
    end
  end

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NRD; i++) rd_q[i] <= '0;
      rpend_q <= '0;
    end else if (bus.RE) begin
      for (int i = 0; i < NRD; i++) rd_q[i] <= rd_nxt[i];
      rpend_q <= rp_nxt;
    end
  end

  always_ff @(posedge CLK_DC or negedge RST) begin
    if (!RST) dbg_q <= '0;
    else      dbg_q <= regs[bus.DBG_SEL];
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    assign bus.RD[g*XLEN +: XLEN] = rd_q[g];
  end

  assign bus.RPEND    = rpend_q;
  assign bus.DBG      = dbg_q;
  assign bus.CLR_BUSY = (state_q == CLR_RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized self-checking bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .CLK_DC (clk),
    .RST    (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [XLEN-1:0] mreg   [NREG];
  bit              mpend  [NREG];
  logic [XLEN-1:0] exp_rd [NRD];
  bit              exp_rp [NRD];
  logic [XLEN-1:0] exp_dbg;
  int              clr_left;
  int              clr_next;

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) begin
      mreg[k]  = '0;
      mpend[k] = 1'b0;
    end
    for (int i = 0; i < NRD; i++) begin
      exp_rd[i] = '0;
      exp_rp[i] = 1'b0;
    end
    exp_dbg  = '0;
    clr_left = 0;
    clr_next = 1;
  endtask

  // Predict the outcome of the next edge from current inputs, then advance one cycle.
  task automatic cyc();
    int a;
    bit idle;
    idle = (clr_left == 0);
    if (bus.RE) begin
      for (int i = 0; i < NRD; i++) begin
        a = int'(bus.RA[i*AW +: AW]);
        exp_rd[i] = (a == 0) ? '0 : mreg[a];
        exp_rp[i] = mpend[a];
`ifdef REGFILE_BYPASS_EN
        if (idle && bus.WE && bus.WA != 0 && int'(bus.WA) == a) begin
          exp_rd[i] = bus.WD;
          exp_rp[i] = bus.RSV_EN && (int'(bus.RSV_A) == a);
        end
`endif
      end
    end
    exp_dbg = mreg[bus.DBG_SEL];
    if (idle) begin
      if (bus.WE && bus.WA != 0) begin
        mreg[bus.WA]  = bus.WD;
        mpend[bus.WA] = 1'b0;
      end
      if (bus.RSV_EN && bus.RSV_A != 0) mpend[bus.RSV_A] = 1'b1;
      if (bus.CLR_REQ) begin
        for (int k = 0; k < NREG; k++) mpend[k] = 1'b0;
        clr_left = NREG - 1;
        clr_next = 1;
      end
    end else begin
      mreg[clr_next] = '0;
      clr_next++;
      clr_left--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.RE = 0; bus.RA = '0; bus.WE = 0; bus.WA = '0; bus.WD = '0;
    bus.RSV_EN = 0; bus.RSV_A = '0; bus.CLR_REQ = 0; bus.DBG_SEL = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.RD !== '0 || bus.RPEND !== '0 || bus.DBG !== '0 || bus.CLR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: RD=%h RPEND=%b DBG=%h BUSY=%b, want all 0",
               bus.RD, bus.RPEND, bus.DBG, bus.CLR_BUSY);
    end
    rst = 1'b1;
    for (int a = 0; a < NREG; a++) begin
      bus.RE = 1; bus.RA = {AW'(a), AW'(a)}; bus.DBG_SEL = AW'(a);
      cyc();
      vectors++;
      if (bus.RD !== '0 || bus.RPEND !== '0) begin
        miscompares++;
        $display("FAIL reset_read x%0d: RD=%h RPEND=%b, want 0", a, bus.RD, bus.RPEND);
      end
      vectors++;
      if (bus.DBG !== '0) begin
        miscompares++;
        $display("FAIL reset_dbg x%0d: DBG=%h, want 0", a, bus.DBG);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_basic();
    bus.WE = 1; bus.WA = 5; bus.WD = 32'hDEADBEEF;
    cyc();
    bus.WA = 0; bus.WD = 32'h1234;
    cyc();
    bus.WE = 0; bus.RE = 1; bus.RA = {AW'(0), AW'(5)}; bus.DBG_SEL = 0;
    cyc();
    vectors++;
    if (bus.RD[31:0] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_x5: RD0=%h, want deadbeef", bus.RD[31:0]);
    end
    vectors++;
    if (bus.RD[63:32] !== 32'h0) begin
      miscompares++;
      $display("FAIL write_x0_discard: RD1=%h, want 0", bus.RD[63:32]);
    end
    bus.DBG_SEL = 5;
    cyc();
    vectors++;
    if (bus.DBG !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL dbg_x5: DBG=%h, want deadbeef", bus.DBG);
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    logic [XLEN-1:0] first;
`ifdef REGFILE_BYPASS_EN
    first = 32'hA5A5A5A5;
`else
    first = 32'h12345678;
`endif
    bus.WE = 1; bus.WA = 7; bus.WD = 32'h12345678;
    cyc();
    bus.WD = 32'hA5A5A5A5; bus.RE = 1; bus.RA = {AW'(0), AW'(7)};
    cyc();
    vectors++;
    if (bus.RD[31:0] !== first) begin
      miscompares++;
      $display("FAIL same_cycle_rd: RD0=%h, want %h", bus.RD[31:0], first);
    end
    bus.WE = 0;
    cyc();
    vectors++;
    if (bus.RD[31:0] !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL next_cycle_rd: RD0=%h, want a5a5a5a5", bus.RD[31:0]);
    end
    idle_inputs();
  endtask

  task automatic test_reserve();
    bus.RSV_EN = 1; bus.RSV_A = 9;
    cyc();
    bus.RSV_EN = 0; bus.RE = 1; bus.RA = {AW'(9), AW'(9)};
    cyc();
    vectors++;
    if (bus.RPEND !== 2'b11) begin
      miscompares++;
      $display("FAIL reserve_pend: RPEND=%b, want 11", bus.RPEND);
    end
    bus.RE = 0; bus.WE = 1; bus.WA = 9; bus.WD = 32'h11;
    cyc();
    bus.WE = 0; bus.RE = 1;
    cyc();
    vectors++;
    if (bus.RPEND !== 2'b00 || bus.RD[31:0] !== 32'h11) begin
      miscompares++;
      $display("FAIL release_pend: RPEND=%b RD0=%h, want 00 / 11", bus.RPEND, bus.RD[31:0]);
    end
    bus.RE = 0; bus.WE = 1; bus.RSV_EN = 1; bus.RSV_A = 9; bus.WD = 32'h11;
    cyc();
    bus.WE = 0; bus.RSV_EN = 0; bus.RE = 1;
    cyc();
    vectors++;
    if (bus.RPEND !== 2'b11 || bus.RD[31:0] !== 32'h11) begin
      miscompares++;
      $display("FAIL reserve_wins: RPEND=%b RD0=%h, want 11 / 11", bus.RPEND, bus.RD[31:0]);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.RE      = $urandom_range(0, 3) != 0;
      bus.RA      = NRD*AW'($urandom);
      bus.WE      = $urandom_range(0, 1);
      bus.WA      = AW'($urandom);
      bus.WD      = $urandom;
      bus.RSV_EN  = $urandom_range(0, 3) == 0;
      bus.RSV_A   = ($urandom_range(0, 1) == 1) ? bus.WA : AW'($urandom);
      bus.CLR_REQ = $urandom_range(0, 63) == 0;
      bus.DBG_SEL = AW'($urandom);
      cyc();
      for (int i = 0; i < NRD; i++) begin
        vectors++;
        if (bus.RD[i*XLEN +: XLEN] !== exp_rd[i] || bus.RPEND[i] !== exp_rp[i]) begin
          miscompares++;
          $display("FAIL rand_rd cyc %0d port %0d: RD=%h RPEND=%b, want %h / %b",
                   n, i, bus.RD[i*XLEN +: XLEN], bus.RPEND[i], exp_rd[i], exp_rp[i]);
        end
      end
      vectors++;
      if (bus.DBG !== exp_dbg || bus.CLR_BUSY !== (clr_left != 0)) begin
        miscompares++;
        $display("FAIL rand_dbg_busy cyc %0d: DBG=%h BUSY=%b, want %h / %b",
                 n, bus.DBG, bus.CLR_BUSY, exp_dbg, clr_left != 0);
      end
    end
    idle_inputs();
    while (clr_left != 0) cyc();
  endtask

  task automatic test_clear();
    int n;
    for (int a = 1; a < NREG; a++) begin
      bus.WE = 1; bus.WA = AW'(a); bus.WD = $urandom | 32'h1;
      cyc();
    end
    bus.WE = 0; bus.RSV_EN = 1; bus.RSV_A = 3;
    cyc();
    bus.RSV_EN = 0; bus.CLR_REQ = 1;
    cyc();
    vectors++;
    if (bus.CLR_BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_start: BUSY=%b, want 1", bus.CLR_BUSY);
    end
    bus.WE = 1; bus.RSV_EN = 1;
    n = 0;
    while (bus.CLR_BUSY === 1'b1 && n < 100) begin
      bus.WA = AW'($urandom_range(1, NREG - 1)); bus.WD = $urandom | 32'h1;
      bus.RSV_A = AW'($urandom_range(1, NREG - 1));
      cyc();
      n++;
    end
    idle_inputs();
    vectors++;
    if (n != NREG - 1) begin
      miscompares++;
      $display("FAIL clr_duration: busy %0d cycles, want %0d", n, NREG - 1);
    end
    for (int a = 0; a < NREG; a++) begin
      bus.RE = 1; bus.RA = {AW'(a), AW'(a)};
      cyc();
      vectors++;
      if (bus.RD !== '0 || bus.RPEND !== '0) begin
        miscompares++;
        $display("FAIL clr_result x%0d: RD=%h RPEND=%b, want 0", a, bus.RD, bus.RPEND);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    bus.WE = 1; bus.WA = 20; bus.WD = 32'hCAFE0020;
    cyc();
    bus.WE = 0; bus.RSV_EN = 1; bus.RSV_A = 20;
    cyc();
    bus.RSV_EN = 0; bus.CLR_REQ = 1;
    cyc();
    bus.CLR_REQ = 0; bus.RE = 1; bus.RA = {AW'(0), AW'(20)}; bus.DBG_SEL = 20;
    repeat (9) cyc();
    vectors++;
    if (bus.RD[31:0] !== 32'hCAFE0020 || bus.DBG !== 32'hCAFE0020 || bus.CLR_BUSY !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_clear_read: RD0=%h DBG=%h BUSY=%b, want cafe0020 / cafe0020 / 1",
               bus.RD[31:0], bus.DBG, bus.CLR_BUSY);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.RD !== '0 || bus.RPEND !== '0 || bus.DBG !== '0 || bus.CLR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_clear_reset: RD=%h RPEND=%b DBG=%h BUSY=%b, want all 0",
               bus.RD, bus.RPEND, bus.DBG, bus.CLR_BUSY);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    vectors++;
    if (bus.RD !== '0 || bus.DBG !== '0 || bus.CLR_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_read: RD=%h DBG=%h BUSY=%b, want 0", bus.RD, bus.DBG, bus.CLR_BUSY);
    end
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    test_reset();
    test_write_basic();
    test_same_cycle();
    test_reserve();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation ran past 500000 time units");
    $fatal(1, "timeout");
  end

endmodule
